uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte buffer placed directly upstream of the UART transmitter. It accepts bytes from the host logic with a single-cycle write strobe and stores them in a circular FIFO. It launches each byte into the transmitter using that block's one-cycle data-valid pulse. It waits for the transmitter's done pulse before launching the next byte, so back-to-back host writes produce back-to-back serial frames with no lost bytes.

## Interface
- DEPTH, 16, FIFO entries; must equal 2**ADDR_WIDTH
- ADDR_WIDTH, 4, pointer width
- i_Clock  in  1  system clock, all logic on rising edge
- i_Rst_L  in  1  asynchronous, active-low reset
- i_Wr_DV  in  1  write strobe, one byte per cycle while high
- i_Wr_Byte  in  8  byte to enqueue
- o_Full  out  1  count == DEPTH
- o_Empty  out  1  count == 0
- o_Count  out  ADDR_WIDTH+1  bytes currently stored (excludes byte in flight)
- o_Overflow  out  1  one-cycle pulse: write rejected because full
- o_Busy  out  1  state != S_IDLE or !o_Empty
- o_TX_DV  out  1  to transmitter data-valid; one-cycle pulse per byte
- o_TX_Byte  out  8  to transmitter byte; held until next launch
- i_TX_Active  in  1  from transmitter: frame in progress
- i_TX_Done  in  1  from transmitter: one-cycle pulse at end of stop bit

## Operation
- Storage: DEPTH x 8 register array, write pointer wr_ptr, read pointer rd_ptr (ADDR_WIDTH bits, wrap modulo DEPTH), count (ADDR_WIDTH+1 bits).
- Write: i_Wr_DV && !o_Full -> mem[wr_ptr] <= i_Wr_Byte, wr_ptr+1.
- Write when full: data dropped, o_Overflow high for the following cycle. This holds even if a pop occurs in the same cycle.
- Pop: occurs only on launch, in S_IDLE.
- Count: +1 on accepted write only, -1 on pop only, unchanged when both occur. Never exceeds DEPTH and never underflows.
- Launch FSM:
  - S_IDLE: if count != 0 and i_TX_Active == 0, then o_TX_DV <= 1, o_TX_Byte <= mem[rd_ptr], rd_ptr+1, -> S_LAUNCH.
  - S_LAUNCH: o_TX_DV <= 0 -> S_WAIT_DONE.
  - S_WAIT_DONE: on i_TX_Done -> S_GAP; otherwise hold.
  - S_GAP: one idle cycle that covers the transmitter's cleanup cycle -> S_IDLE.
- The i_TX_Active guard in S_IDLE prevents a launch while the transmitter is still busy, for example after a reset of this block alone. Any data-valid pulse the transmitter ignores would lose the byte.
- o_TX_Byte is registered and stable from the launch edge until the next launch.

## Timing
- Reset (i_Rst_L low, asynchronous) sets:
  - wr_ptr, rd_ptr, count = 0
  - state = S_IDLE
  - o_TX_DV = 0, o_TX_Byte = 0x00, o_Overflow = 0
  - o_Full = 0, o_Empty = 1, o_Busy = 0
- Reset mid-frame flushes the FIFO. A byte already in flight is finished by the transmitter; no new launch occurs until i_TX_Active is low.
- Latency, empty FIFO with idle transmitter: write sampled at edge N; count = 1 after edge N; o_TX_DV high from edge N+1 to edge N+2.
- o_Full, o_Empty and o_Count are registered and reflect the state after the last edge.
- o_Overflow rises on the edge that samples the rejected write and lasts exactly one cycle.
- Inter-byte gap: next o_TX_DV rises 2 edges after the edge that samples i_TX_Done, provided i_TX_Active is low.
- o_TX_DV is never high for two consecutive cycles.

## Test plan
Bench configuration: DEPTH=16; transmitter with CLKS_PER_BIT=4; its serial output drives a receiver that captures every byte.
- Reset check: hold i_Rst_L low, toggle i_Wr_DV -> all outputs at reset values, o_Empty=1, no o_TX_DV; release -> still idle.
- Single byte: write 0x3F at edge N -> o_TX_DV high only between N+1 and N+2, o_TX_Byte=0x3F, receiver gets 0x3F, o_Busy falls after S_GAP.
- Fill/overflow: 18 back-to-back writes 0x00..0x11 ->
  - o_Full rises after the 17th write.
  - The 18th write (0x11) is dropped and o_Overflow pulses once.
  - Receiver gets 0x00..0x10 in order (17 bytes).
- Wrap-around: three rounds of writing 10 bytes (0xA0.., 0xB0.., 0xC0..) and draining -> 30 bytes received in order; pointers cross DEPTH without corruption.
- Simultaneous write and pop: count=1 with transmitter idle, write 0x55 on the launch cycle -> o_Count stays 1, bytes sent in order.
- Reset mid-frame: assert i_Rst_L low while i_TX_Active=1 with 5 bytes queued -> FIFO empty after reset; then write 0x77 -> o_TX_DV held low until i_TX_Active falls, then 0x77 is launched.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter: launches one byte per data-valid pulse,
// waits for the transmitter's done pulse plus one cleanup cycle before the next launch.
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_Clock,
    input  logic                  i_Rst_L,
    input  logic                  i_Wr_DV,
    input  logic [7:0]            i_Wr_Byte,
    output logic                  o_Full,
    output logic                  o_Empty,
    output logic [ADDR_WIDTH:0]   o_Count,
    output logic                  o_Overflow,
    output logic                  o_Busy,
    output logic                  o_TX_DV,
    output logic [7:0]            o_TX_Byte,
    input  logic                  i_TX_Active,
    input  logic                  i_TX_Done
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_DONE, S_GAP} state_t;

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    state_t                state;
    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  wr_en, pop;

    assign wr_en  = i_Wr_DV && !o_Full;
    // Never launch into a transmitter that is still busy; it would ignore the pulse.
    assign pop    = (state == S_IDLE) && !o_Empty && !i_TX_Active;
    assign o_Busy = (state != S_IDLE) || !o_Empty;

    always_comb begin
        count_nxt = o_Count;
        case ({wr_en, pop})
            2'b10:   count_nxt = o_Count + 1'b1;
            2'b01:   count_nxt = o_Count - 1'b1;
            default: count_nxt = o_Count;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (wr_en)
            mem[wr_ptr] <= i_Wr_Byte;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_Count    <= '0;
            o_Full     <= 1'b0;
            o_Empty    <= 1'b1;
            o_Overflow <= 1'b0;
            o_TX_DV    <= 1'b0;
            o_TX_Byte  <= 8'h00;
            state      <= S_IDLE;
        end else begin
            o_Count    <= count_nxt;
            o_Full     <= (count_nxt == FULL_CNT);
            o_Empty    <= (count_nxt == '0);
            o_Overflow <= i_Wr_DV && o_Full;
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        o_TX_DV   <= 1'b1;
                        o_TX_Byte <= mem[rd_ptr];
                        rd_ptr    <= rd_ptr + 1'b1;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    o_TX_DV <= 1'b0;
                    state   <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (i_TX_Done)
                        state <= S_GAP;
                end
                S_GAP:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: behavioural serial transmitter/receiver around the DUT,
// queue-based FIFO reference model, directed steps plus a random write phase.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CPB   = 4;

    logic          i_Clock = 1'b0;
    logic          i_Rst_L = 1'b0;
    logic          i_Wr_DV = 1'b0;
    logic [7:0]    i_Wr_Byte = 8'h00;
    logic          o_Full, o_Empty, o_Overflow, o_Busy, o_TX_DV;
    logic [AW:0]   o_Count;
    logic [7:0]    o_TX_Byte;
    logic          tx_active = 1'b0;
    logic          tx_done = 1'b0;
    logic          tx_line = 1'b1;
    logic [9:0]    frame = '1;
    int            bitn = 0;
    int            clkc = 0;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    logic [7:0] sent_q[$];
    logic [7:0] rx_q[$];
    logic       prev_dv = 1'b0;
    logic       own_inflight = 1'b0;
    int         gap = 0;
    logic       wr_s;
    logic [7:0] wb_s;
    int         pre;

    always #5 i_Clock = ~i_Clock;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .i_Clock     (i_Clock),
        .i_Rst_L     (i_Rst_L),
        .i_Wr_DV     (i_Wr_DV),
        .i_Wr_Byte   (i_Wr_Byte),
        .o_Full      (o_Full),
        .o_Empty     (o_Empty),
        .o_Count     (o_Count),
        .o_Overflow  (o_Overflow),
        .o_Busy      (o_Busy),
        .o_TX_DV     (o_TX_DV),
        .o_TX_Byte   (o_TX_Byte),
        .i_TX_Active (tx_active),
        .i_TX_Done   (tx_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: ignores data-valid while a frame is in progress, like the real one.
    always @(posedge i_Clock) begin
        tx_done <= 1'b0;
        if (!tx_active) begin
            if (o_TX_DV) begin
                frame     <= {1'b1, o_TX_Byte, 1'b0};
                tx_active <= 1'b1;
                bitn      <= 0;
                clkc      <= 0;
                tx_line   <= 1'b0;
            end
        end else if (clkc == CPB-1) begin
            clkc <= 0;
            if (bitn == 9) begin
                tx_active <= 1'b0;
                tx_done   <= 1'b1;
                tx_line   <= 1'b1;
            end else begin
                bitn    <= bitn + 1;
                tx_line <= frame[bitn+1];
            end
        end else begin
            clkc <= clkc + 1;
        end
    end

    // Receiver model: mid-bit sampling of the serial line.
    initial begin
        logic [7:0] b;
        forever begin
            @(posedge i_Clock);
            if (tx_line == 1'b0) begin
                repeat (CPB/2) @(posedge i_Clock);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(posedge i_Clock);
                    b[k] = tx_line;
                end
                repeat (CPB) @(posedge i_Clock);
                rx_q.push_back(b);
            end
        end
    end

    // Reference model: queue of stored bytes, updated once per edge from the sampled inputs.
    always begin
        @(posedge i_Clock);
        wr_s = i_Wr_DV;
        wb_s = i_Wr_Byte;
        pre  = mq.size();
        #1;
        if (!i_Rst_L) begin
            mq.delete();
            prev_dv = 1'b0;
            gap = 0;
            own_inflight = 1'b0;
            chk("rst_dv", o_TX_DV, 0);
            chk("rst_byte", o_TX_Byte, 0);
            chk("rst_cnt", o_Count, 0);
            chk("rst_empty", o_Empty, 1);
            chk("rst_full", o_Full, 0);
            chk("rst_ovf", o_Overflow, 0);
            chk("rst_busy", o_Busy, 0);
        end else begin
            if (wr_s && pre < DEPTH) mq.push_back(wb_s);
            chk("ovf", o_Overflow, (wr_s && pre == DEPTH));
            if (o_TX_DV) begin
                chk("pop_nonempty", (pre > 0), 1);
                if (mq.size() > 0) begin
                    chk("tx_byte", o_TX_Byte, mq[0]);
                    sent_q.push_back(mq.pop_front());
                end
                own_inflight = 1'b1;
            end
            chk("dv_twice", (prev_dv && o_TX_DV), 0);
            chk("dv_while_active", (o_TX_DV && tx_active), 0);
            chk("count", o_Count, mq.size());
            chk("full", o_Full, (mq.size() == DEPTH));
            chk("empty", o_Empty, (mq.size() == 0));
            if (gap > 0) begin
                gap--;
                if (gap == 0) chk("gap_launch", o_TX_DV, 1);
            end
            if (tx_done && own_inflight) begin
                own_inflight = 1'b0;
                if (mq.size() > 0) gap = 3;
            end
            prev_dv = o_TX_DV;
        end
    end

    task automatic wr(input logic [7:0] b);
        @(negedge i_Clock);
        i_Wr_DV   = 1'b1;
        i_Wr_Byte = b;
    endtask

    task automatic idle_in();
        @(negedge i_Clock);
        i_Wr_DV = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        idle_in();
        while ((o_Busy || tx_active) && n < budget) begin
            @(posedge i_Clock); #1;
            n++;
        end
        chk("idle_timeout", (n < budget), 1);
        repeat (3) @(posedge i_Clock);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!tx_done && n < budget) begin
            @(posedge i_Clock); #1;
            n++;
        end
        chk("done_timeout", (n < budget), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int thr;
        int rx0;
        // reset held, write strobe toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge i_Clock);
            i_Wr_DV   = ~i_Wr_DV;
            i_Wr_Byte = 8'hE0 + 8'(i);
        end
        @(negedge i_Clock);
        i_Wr_DV = 1'b0;
        i_Rst_L = 1'b1;
        repeat (4) @(posedge i_Clock);
        #1;
        chk("post_rst_busy", o_Busy, 0);
        chk("post_rst_empty", o_Empty, 1);

        // single byte latency
        wr(8'h3F);
        @(posedge i_Clock); #1;
        chk("s_n_dv", o_TX_DV, 0);
        chk("s_n_cnt", o_Count, 1);
        idle_in();
        @(posedge i_Clock); #1;
        chk("s_n1_dv", o_TX_DV, 1);
        chk("s_n1_byte", o_TX_Byte, 8'h3F);
        @(posedge i_Clock); #1;
        chk("s_n2_dv", o_TX_DV, 0);
        chk("s_n2_byte", o_TX_Byte, 8'h3F);
        wait_done(200);
        @(posedge i_Clock); #1;
        chk("s_gap_busy", o_Busy, 1);
        @(posedge i_Clock); #1;
        chk("s_idle_busy", o_Busy, 0);
        wait_idle(200);
        chk("s_rx_n", rx_q.size(), 1);

        // fill and overflow
        for (int i = 0; i < 18; i++) begin
            wr(8'(i));
            @(posedge i_Clock); #1;
            if (i == 16) chk("fill_full", o_Full, 1);
            if (i == 17) chk("fill_ovf", o_Overflow, 1);
        end
        idle_in();
        @(posedge i_Clock); #1;
        chk("ovf_once", o_Overflow, 0);
        wait_idle(1500);
        chk("fill_rx_n", rx_q.size(), 18);

        // wrap-around over three rounds
        for (int r = 0; r < 3; r++) begin
            rx0 = rx_q.size();
            for (int i = 0; i < 10; i++) wr(8'hA0 + 8'(r*16) + 8'(i));
            wait_idle(1000);
            chk("wrap_rx_n", rx_q.size() - rx0, 10);
        end

        // write on the launch cycle
        wr(8'h5A);
        wr(8'h55);
        @(posedge i_Clock); #1;
        chk("sim_cnt", o_Count, 1);
        chk("sim_dv", o_TX_DV, 1);
        wait_idle(300);

        // reset mid-frame
        for (int i = 0; i < 6; i++) wr(8'h60 + 8'(i));
        idle_in();
        repeat (6) @(posedge i_Clock);
        #1;
        chk("mf_active", tx_active, 1);
        chk("mf_cnt", o_Count, 5);
        @(negedge i_Clock);
        i_Rst_L = 1'b0;
        #1;
        chk("mf_async_empty", o_Empty, 1);
        chk("mf_async_cnt", o_Count, 0);
        repeat (2) @(negedge i_Clock);
        i_Rst_L = 1'b1;
        wr(8'h77);
        idle_in();
        n = 0;
        while (tx_active && n < 300) begin
            chk("mf_hold", o_TX_DV, 0);
            @(posedge i_Clock); #1;
            n++;
        end
        chk("mf_timeout", (n < 300), 1);
        @(posedge i_Clock); #1;
        chk("mf_launch_dv", o_TX_DV, 1);
        chk("mf_launch_byte", o_TX_Byte, 8'h77);
        wait_idle(300);

        // random writes at varying density
        for (int i = 0; i < 600; i++) begin
            thr = (i < 200) ? 5 : ((i < 400) ? 40 : 15);
            @(negedge i_Clock);
            i_Wr_DV   = ($urandom_range(0, 99) < thr);
            i_Wr_Byte = 8'($urandom);
        end
        wait_idle(2000);

        chk("model_drained", mq.size(), 0);
        chk("rx_total", rx_q.size(), sent_q.size());
        for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++)
            chk("rx_data", rx_q[i], sent_q[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
